// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the switch-driven frame transmitter.
package frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Field map of the 10-bit switch word
  localparam int CH_MSB  = 9;
  localparam int CH_LSB  = 8;
  localparam int PAY_MSB = 7;
  localparam int PAY_LSB = 0;

  // Bit period in clk cycles after reset
  localparam int DEFAULT_DIV = 100;

endpackage

// File: rtl/bit_timer.sv
// Bit-slot timer: counts 0..period-1 while enabled and flags the last cycle.
// The count only returns to zero through clr, so the owner clears it on every
// tick to start the next slot.
module bit_timer #(
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = en && (count_q == (period - ONE));

  // Next count: clear has priority, otherwise advance while enabled
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_tx_sequencer.sv
// Frame transmitter controller: captures channel + payload from SW on a start
// edge and shifts a start/8-data/stop frame onto one of four idle-high lines.
module frame_tx_sequencer #(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 10,
  parameter int DEFAULT_DIV = frame_tx_pkg::DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       start,
  input  logic       sel,
  input  logic       mode,
  input  logic [9:0] SW,
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  import frame_tx_pkg::*;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  period_q, period_d;
  logic              start_q, start_d;
  logic [1:0]        ch_q, ch_d;
  logic [DATA_W-1:0] pay_q, pay_d;
  logic              mode_q, mode_d;
  logic [2:0]        idx_q, idx_d;
  logic              done_seen_q, done_seen_d;

  logic              start_edge;
  logic              tmr_clr;
  logic              tick;
  logic              data_bit;
  logic              line_bit;
  logic [3:0]        lines;
  logic [3:0]        status;

  assign start_d    = start;
  assign start_edge = start & ~start_q;
  assign busy       = (state_q == START) || (state_q == DATA) || (state_q == STOP);
  assign done       = (state_q == DONE);

  bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (busy),
    .period (period_q),
    .tick   (tick)
  );

  // Next-state, latch updates and timer clear; every slot boundary clears the timer
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    ch_d        = ch_q;
    pay_d       = pay_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    done_seen_d = done_seen_q;
    tmr_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          // A zero period would never tick, so it is forced to one cycle
          period_d = (SW == 10'd0) ? DIV_W'(1) : DIV_W'(SW);
        end else if (start_edge) begin
          ch_d        = SW[CH_MSB:CH_LSB];
          pay_d       = SW[PAY_MSB:PAY_LSB];
          mode_d      = mode;
          idx_d       = 3'd0;
          done_seen_d = 1'b0;
          tmr_clr     = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = 3'd0;
          tmr_clr = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          tmr_clr = 1'b1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tmr_clr = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_seen_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and latch registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      period_q    <= DIV_W'(DEFAULT_DIV);
      start_q     <= 1'b0;
      ch_q        <= 2'd0;
      pay_q       <= '0;
      mode_q      <= 1'b0;
      idx_q       <= 3'd0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      start_q     <= start_d;
      ch_q        <= ch_d;
      pay_q       <= pay_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Line drive and status view; only the latched channel ever leaves the idle level
  always_comb begin
    data_bit = mode_q ? pay_q[3'd7 - idx_q] : pay_q[idx_q];
    case (state_q)
      START:   line_bit = 1'b0;
      DATA:    line_bit = data_bit;
      default: line_bit = 1'b1;
    endcase
    lines       = 4'b1111;
    lines[ch_q] = line_bit;
    status      = sel ? {1'b0, idx_q} : {busy, done_seen_q, ch_q};
    out         = {status, lines};
  end

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Directed bench for frame_tx_sequencer with hand-computed frame waveforms.
module tb_frame_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       init = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] SW = 10'd0;
  logic [7:0] out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  frame_tx_sequencer dut (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .start (start),
    .sel   (sel),
    .mode  (mode),
    .SW    (SW),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic load_period(input logic [9:0] val);
    @(negedge clk);
    init = 1'b1;
    SW   = val;
    idle_cycles(2);
    init = 1'b0;
    @(negedge clk);
  endtask

  // exp_bits: slot 0 (start bit) at bit 9 down to slot 9 (stop bit) at bit 0
  task automatic run_frame(input string tag, input logic [9:0] sw, input logic md,
                           input int p, input logic [9:0] exp_bits,
                           input bit extra_edge, input bit mid_init, input bit sel_peek);
    int       busy_cnt;
    int       done_cnt;
    int       done_pos;
    int       line_err;
    int       other_err;
    int       slot;
    int       last;
    logic [1:0] ch;
    logic     exp_line;
    ch        = sw[9:8];
    busy_cnt  = 0;
    done_cnt  = 0;
    done_pos  = -1;
    line_err  = 0;
    other_err = 0;
    last      = 13 * p + 3;
    SW    = sw;
    mode  = md;
    start = 1'b1;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_pos < 0) done_pos = n;
      end
      if (n <= 10 * p) begin
        slot     = (n - 1) / p;
        exp_line = exp_bits[9 - slot];
        if (out[ch] !== exp_line) line_err++;
        if (((n - 1) % p) == 0)
          chk($sformatf("%s line slot%0d", tag, slot), 32'(out[ch]), 32'(exp_line));
      end else if (out[ch] !== 1'b1) begin
        line_err++;
      end
      for (int k = 0; k < 4; k++)
        if (k != int'(ch) && out[k] !== 1'b1) other_err++;
      if (n == 1) chk({tag, " status"}, 32'(out[7:4]), 32'({2'b10, ch}));
      if (sel_peek && n == 4 * p + 1) begin
        chk({tag, " sel idx"}, 32'(out[7:4]), 32'(4'b0011));
        sel = 1'b0;
      end
      // drives for the next edge
      if (n == 1) start = 1'b0;
      if (extra_edge && n == 3 * p + 1) start = 1'b1;
      if (extra_edge && n == 3 * p + 2) start = 1'b0;
      if (mid_init && n == 2 * p + 1) begin
        init = 1'b1;
        SW   = 10'd7;
      end
      if (mid_init && n == 2 * p + 3) begin
        init = 1'b0;
        SW   = sw;
      end
      if (sel_peek && n == 4 * p) sel = 1'b1;
    end
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(10 * p));
    chk({tag, " done count"}, 32'(done_cnt), 32'd1);
    chk({tag, " done position"}, 32'(done_pos), 32'(10 * p + 1));
    chk({tag, " line errors"}, 32'(line_err), 32'd0);
    chk({tag, " other lines"}, 32'(other_err), 32'd0);
    chk({tag, " done_seen view"}, 32'(out[7:4]), 32'({2'b01, ch}));
  endtask

  initial begin
    int busy_seen;
    // reset state
    #1;
    chk("reset out", 32'(out), 32'h0F);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);
    chk("post reset out", 32'(out), 32'h0F);

    // default period 100, payload 0x01 LSB first on ch0
    run_frame("p100", 10'b00_0000_0001, 1'b0, 100, 10'b0100000001, 1'b0, 1'b0, 1'b0);

    // period 4, ch2, payload 0x35 LSB first
    load_period(10'd4);
    run_frame("lsb", 10'b10_0011_0101, 1'b0, 4, 10'b0101011001, 1'b0, 1'b0, 1'b0);
    // MSB first, with a sel peek mid-frame
    run_frame("msb", 10'b10_0011_0101, 1'b1, 4, 10'b0001101011, 1'b0, 1'b0, 1'b1);
    // stray start edge and init while busy must not disturb the frame
    run_frame("ignore", 10'b10_0011_0101, 1'b0, 4, 10'b0101011001, 1'b1, 1'b1, 1'b0);

    // init and start in the same idle cycle: period loads, no frame
    @(negedge clk);
    init  = 1'b1;
    start = 1'b1;
    SW    = 10'd0;
    @(negedge clk);
    init  = 1'b0;
    start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    chk("init beats start", 32'(busy_seen), 32'd0);

    // period 1 from SW=0, ch3, payload 0x80 LSB first
    run_frame("p1", 10'b11_1000_0000, 1'b0, 1, 10'b0000000011, 1'b0, 1'b0, 1'b0);

    // asynchronous reset during DATA
    load_period(10'd4);
    SW    = 10'b01_0000_0000;
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(8);
    chk("pre-abort line low", 32'(out[1]), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("abort lines", 32'(out[3:0]), 32'hF);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort status", 32'(out), 32'h0F);
    // period must be back at the default
    run_frame("after rst", 10'b00_0000_0001, 1'b0, 100, 10'b0100000001, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
